block_ram_arbiter: RTL
======================

BLOCK_RAM_ARBITER -- requirements
Module: block_ram_arbiter

Interface
REQ-001 SHALL have parameter RAM_ADDR_BITS, default 13, RAM address width.
REQ-002 SHALL have parameter RAM_WIDTH, default 8, RAM data width.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst_sync  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports h_req/h_we  input  1 each  host request, 1=write 0=read.
REQ-006 SHALL have ports h_addr  input  RAM_ADDR_BITS, and h_wdata  input  RAM_WIDTH  host command.
REQ-007 SHALL have port h_lock  input  1  host strict priority while high.
REQ-008 SHALL have ports h_ack/h_rvalid  output  1 each, and h_rdata  output  RAM_WIDTH  host responses.
REQ-009 SHALL have ports c_req, c_we, c_addr, c_wdata, c_ack, c_rvalid, c_rdata  capture port, same widths/meaning as host.
REQ-010 SHALL have ports ram_write_enable/ram_read_enable  output  1 each  RAM strobes.
REQ-011 SHALL have ports ram_address  output  RAM_ADDR_BITS, and ram_write_data  output  RAM_WIDTH  RAM command.
REQ-012 SHALL have port ram_read_data  input  RAM_WIDTH  RAM data, valid the cycle after ram_read_enable.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, ISSUE, WAIT; every output registered.
REQ-015 Requester SHALL hold req/we/addr/wdata stable until ack; arbiter SHALL sample only in IDLE.
REQ-016 IDLE (cycle N) with any req: SHALL pick winner and go to ISSUE at N+1; no req: stay IDLE.
REQ-017 ISSUE (N+1): winner's addr/wdata on ram_address/ram_write_data, exactly one of ram_write_enable (we=1) or ram_read_enable (we=0) high, winner's ack high one cycle.
REQ-018 WAIT (N+2): strobes low, requests ignored; for a read, capture ram_read_data at end of cycle.
REQ-019 At N+3: return to IDLE; for a read, winner's rdata updated and rvalid high exactly one cycle.
REQ-020 Throughput SHALL be one access per 3 cycles; read latency req-sampled to rvalid 3 cycles.
REQ-021 Arbitration SHALL be round-robin: on simultaneous req, grant the port not granted last; after reset host wins first tie.
REQ-022 h_lock high in IDLE: host wins any tie regardless of pointer; capture granted only when h_req low.
REQ-023 Single requester SHALL be granted immediately regardless of pointer; pointer updates only on grant.
REQ-024 ram_write_enable and ram_read_enable SHALL never be high together, and never outside ISSUE.
REQ-025 ram_address/ram_write_data SHALL hold last value outside ISSUE; addresses pass unmodified, no wrap.
REQ-026 h_rdata/c_rdata SHALL hold value until that port's next read completes; writes never change them.
REQ-027 Loser's req SHALL remain pending, served at next IDLE sample; a req dropped before ack is discarded silently.
REQ-028 ack and rvalid SHALL never assert on the non-winning port.

Reset
REQ-029 rst_sync high SHALL force IDLE, all acks/rvalids/strobes/busy 0, rdata/ram_address/ram_write_data 0, pointer to host-favoured.
REQ-030 Reset mid-ISSUE/WAIT SHALL abort access: no rvalid issued; any RAM write already strobed stays.
REQ-031 First edge with rst_sync low SHALL sample requests normally.

Verification
REQ-032 Host write addr 0x0005 data 0xA5 -> ram_write_enable 1 cycle at N+1 with 0x0005/0xA5, h_ack at N+1, no h_rvalid.
REQ-033 Host read 0x0005 after REQ-032 -> ram_read_enable at N+1, h_rvalid at N+3, h_rdata 0xA5.
REQ-034 h_req and c_req both held continuously from reset -> grants host, capture, host, capture; acks 3 cycles apart.
REQ-035 Same as REQ-034 with h_lock=1 -> only host granted; capture granted 3 cycles after h_req drops.
REQ-036 Capture read 0x1FFF, rst_sync pulsed in WAIT -> no c_rvalid, busy 0 next cycle, c_rdata 0.
REQ-037 Random two-port traffic vs reference memory model -> all rdata match, strobes never both high, no ack off-winner.

Source files
------------

// File: rtl/block_ram_arbiter_if.sv
// Host and capture requester bundle for the block RAM arbiter.
// The arbiter connects through the slave modport and requesters through the master modport.
interface block_ram_arbiter_if #(
  parameter int unsigned RAM_ADDR_BITS = 13,
  parameter int unsigned RAM_WIDTH     = 8
);
  logic                     h_req;
  logic                     h_we;
  logic [RAM_ADDR_BITS-1:0] h_addr;
  logic [RAM_WIDTH-1:0]     h_wdata;
  logic                     h_lock;
  logic                     h_ack;
  logic                     h_rvalid;
  logic [RAM_WIDTH-1:0]     h_rdata;

  logic                     c_req;
  logic                     c_we;
  logic [RAM_ADDR_BITS-1:0] c_addr;
  logic [RAM_WIDTH-1:0]     c_wdata;
  logic                     c_ack;
  logic                     c_rvalid;
  logic [RAM_WIDTH-1:0]     c_rdata;

  modport master (
    output h_req, h_we, h_addr, h_wdata, h_lock,
    input  h_ack, h_rvalid, h_rdata,
    output c_req, c_we, c_addr, c_wdata,
    input  c_ack, c_rvalid, c_rdata
  );

  modport slave (
    input  h_req, h_we, h_addr, h_wdata, h_lock,
    output h_ack, h_rvalid, h_rdata,
    input  c_req, c_we, c_addr, c_wdata,
    output c_ack, c_rvalid, c_rdata
  );
endinterface

// File: rtl/block_ram_arbiter.sv
// Two-port (host/capture) round-robin arbiter onto a single-port block RAM.
// One access per three cycles: IDLE samples, ISSUE strobes the RAM, WAIT collects read data.
module block_ram_arbiter #(
  parameter int unsigned RAM_ADDR_BITS = 13,
  parameter int unsigned RAM_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     rst_sync,
  block_ram_arbiter_if.slave       bus,
  output logic                     ram_write_enable,
  output logic                     ram_read_enable,
  output logic [RAM_ADDR_BITS-1:0] ram_address,
  output logic [RAM_WIDTH-1:0]     ram_write_data,
  input  logic [RAM_WIDTH-1:0]     ram_read_data,
  output logic                     busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic                     win_cap_q, win_cap_d;    // current winner is capture
  logic                     win_we_q, win_we_d;
  logic                     last_cap_q, last_cap_d;  // capture was granted last
  logic                     wr_en_q, wr_en_d;
  logic                     rd_en_q, rd_en_d;
  logic [RAM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [RAM_WIDTH-1:0]     wdata_q, wdata_d;
  logic                     h_ack_q, h_ack_d;
  logic                     c_ack_q, c_ack_d;
  logic                     h_rvalid_q, h_rvalid_d;
  logic                     c_rvalid_q, c_rvalid_d;
  logic [RAM_WIDTH-1:0]     h_rdata_q, h_rdata_d;
  logic [RAM_WIDTH-1:0]     c_rdata_q, c_rdata_d;
  logic                     busy_q, busy_d;
  logic                     pick_cap;

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    win_cap_d  = win_cap_q;
    win_we_d   = win_we_q;
    last_cap_d = last_cap_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    h_ack_d    = 1'b0;
    c_ack_d    = 1'b0;
    h_rvalid_d = 1'b0;
    c_rvalid_d = 1'b0;
    h_rdata_d  = h_rdata_q;
    c_rdata_d  = c_rdata_q;
    pick_cap   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.h_req || bus.c_req) begin
          // Tie goes to the port not granted last unless the host holds lock
          if (bus.h_req && bus.c_req) pick_cap = !bus.h_lock && !last_cap_q;
          else                        pick_cap = bus.c_req;
          state_d    = S_ISSUE;
          win_cap_d  = pick_cap;
          last_cap_d = pick_cap;
          win_we_d   = pick_cap ? bus.c_we : bus.h_we;
          addr_d     = pick_cap ? bus.c_addr : bus.h_addr;
          wdata_d    = pick_cap ? bus.c_wdata : bus.h_wdata;
          wr_en_d    = pick_cap ? bus.c_we : bus.h_we;
          rd_en_d    = pick_cap ? !bus.c_we : !bus.h_we;
          h_ack_d    = !pick_cap;
          c_ack_d    = pick_cap;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        state_d = S_IDLE;
        if (!win_we_q) begin
          if (win_cap_q) begin
            c_rdata_d  = ram_read_data;
            c_rvalid_d = 1'b1;
          end else begin
            h_rdata_d  = ram_read_data;
            h_rvalid_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      state_q    <= S_IDLE;
      win_cap_q  <= 1'b0;
      win_we_q   <= 1'b0;
      last_cap_q <= 1'b1;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      h_ack_q    <= 1'b0;
      c_ack_q    <= 1'b0;
      h_rvalid_q <= 1'b0;
      c_rvalid_q <= 1'b0;
      h_rdata_q  <= '0;
      c_rdata_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_cap_q  <= win_cap_d;
      win_we_q   <= win_we_d;
      last_cap_q <= last_cap_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      h_ack_q    <= h_ack_d;
      c_ack_q    <= c_ack_d;
      h_rvalid_q <= h_rvalid_d;
      c_rvalid_q <= c_rvalid_d;
      h_rdata_q  <= h_rdata_d;
      c_rdata_q  <= c_rdata_d;
      busy_q     <= busy_d;
    end
  end

  assign ram_write_enable = wr_en_q;
  assign ram_read_enable  = rd_en_q;
  assign ram_address      = addr_q;
  assign ram_write_data   = wdata_q;
  assign busy             = busy_q;
  assign bus.h_ack        = h_ack_q;
  assign bus.c_ack        = c_ack_q;
  assign bus.h_rvalid     = h_rvalid_q;
  assign bus.c_rvalid     = c_rvalid_q;
  assign bus.h_rdata      = h_rdata_q;
  assign bus.c_rdata      = c_rdata_q;

endmodule
